tsp_key_feeder: RTL and testbench
=================================

Name: tsp_key_feeder

Overview:
- Upstream sequencer for the TSP matcher array: buffers one search pattern (bytes plus per-byte gap/mask flags) and streams it one byte per cycle onto the matcher's key interface (start, key, last_byte, begin_gap, end_gap, mask, key_length, byte_mode).
- Waits for the matcher's decoder to report match_count_valid, latches the count, then signals done.
- Sits between the host/control register block and the TSP core.

Parameters:
- MAX_KEY_LEN, 256, pattern buffer depth in bytes; must be ≤ 511.
- PTR_W, 9, width of write pointer and length; must satisfy 2^PTR_W > MAX_KEY_LEN.
- CNT_W, 15, width of match_count from the matcher.
- TIMEOUT_CYCLES, 65536, watchdog limit in WAIT_RESULT; used only with the optional feature.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- pat_clear  in  1  empty the pattern buffer and clear overflow; honoured in IDLE only
- pat_we  in  1  append one pattern byte; honoured in IDLE only
- pat_wdata  in  8  pattern byte
- pat_wflags  in  3  {mask, end_gap, begin_gap} for this byte
- go  in  1  start streaming the buffered pattern
- mode_in  in  2  byte mode latched at go (00=1B, 01=2B, 10=3B, 11=4B)
- busy  out  1  FSM not in IDLE
- done  out  1  one-cycle pulse at end of a run
- err  out  1  one-cycle pulse when go is rejected
- timeout  out  1  sticky; set when a run ends by watchdog; cleared on next accepted go
- overflow  out  1  sticky; a write was attempted on a full buffer
- pat_len  out  PTR_W  current buffer fill
- result_count  out  CNT_W  match count latched from the last run
- start, key[7:0], last_byte, begin_gap, end_gap, mask  out  key stream to the TSP core
- key_length  out  9  pattern length, driven for the whole run
- byte_mode  out  2  latched mode_in, driven for the whole run
- match_count  in  CNT_W  from the TSP decoder
- match_count_valid  in  1  from the TSP decoder

Behaviour:
- **Reset:**
  - FSM enters IDLE.
  - Write pointer, pat_len, overflow, timeout and result_count are cleared to 0.
  - All stream outputs, busy, done and err are 0.
  - Reset mid-run aborts immediately; no done pulse.
- **Buffer writes (IDLE only; ignored in any other state):**
  - pat_clear has priority over pat_we in the same cycle.
  - pat_we with pat_len < MAX_KEY_LEN stores {flags, byte} at index pat_len; pat_len increments on the next cycle.
  - pat_we with pat_len == MAX_KEY_LEN is dropped and sets overflow.
- **go in IDLE is rejected (err pulses the next cycle, state stays IDLE) when:**
  - pat_len < 2, or
  - pat_len is not a multiple of (mode_in+1).
- **Otherwise go is accepted:**
  - latch byte_mode = mode_in and key_length = pat_len;
  - clear timeout;
  - go to STREAM.
- go outside IDLE is ignored.
- **STREAM:**
  - One byte per cycle for pat_len cycles, all outputs registered. The first stream cycle is the cycle after go.
  - Index 0: start=1.
  - Index pat_len-1: last_byte=1. start and last_byte are never high together.
  - begin_gap, end_gap and mask equal the stored flags of the byte being driven.
  - Stream is contiguous with no bubbles.
  - After the last byte, all stream strobes return to 0 and the FSM goes to WAIT_RESULT.
- **WAIT_RESULT:**
  - On match_count_valid, latch result_count = match_count, pulse done for the next cycle, and return to IDLE.
  - match_count_valid seen in any other state is ignored.
- busy is high in STREAM and WAIT_RESULT.
- The buffer contents persist across runs, so the same pattern can be re-issued with go alone.

Optional Feature:
- Macro: TSP_KEY_FEEDER_TIMEOUT_EN.
- **Defined:**
  - A counter runs in WAIT_RESULT, cleared on entry.
  - On reaching TIMEOUT_CYCLES without match_count_valid: set timeout, set result_count=0, pulse done, return to IDLE.
  - If match_count_valid arrives in the same cycle as expiry, the valid wins and timeout stays 0.
- **Not defined:**
  - No counter; WAIT_RESULT waits indefinitely.
  - The timeout output is tied to 0.

Test Plan:
- Write 4 bytes "ABCD" with flags 0, then go with mode_in=00:
  - start on the first stream cycle with key=0x41;
  - keys 0x41/0x42/0x43/0x44 on consecutive cycles;
  - last_byte only with 0x44; key_length=4 throughout;
  - then match_count_valid with match_count=7 → done pulse, result_count=7, busy=0.
- Write 3 bytes and go with mode_in=01 → err pulse, no start, busy stays 0.
- Go with pat_len=1 → err pulse.
- Write 257 bytes with MAX_KEY_LEN=256 → pat_len=256, overflow=1; pat_clear → pat_len=0, overflow=0.
- Flags: byte 1 with begin_gap, byte 2 with end_gap, byte 0 with mask → each flag appears exactly in its byte's cycle.
- Reset asserted on the 2nd stream cycle → all outputs 0 the next cycle, state IDLE, no done.
- With TSP_KEY_FEEDER_TIMEOUT_EN and TIMEOUT_CYCLES=16, no match_count_valid → done after 16 WAIT_RESULT cycles, timeout=1, result_count=0.
- Next accepted go → timeout cleared.

Source files
------------

// File: rtl/tsp_key_feeder_if.sv
// Key-stream interface between tsp_key_feeder and the TSP matcher core.
// The feeder drives the key stream; the core returns the match count.
interface tsp_key_feeder_if #(
    parameter int unsigned CNT_W = 15
);
    logic             start;
    logic [7:0]       key;
    logic             last_byte;
    logic             begin_gap;
    logic             end_gap;
    logic             mask;
    logic [8:0]       key_length;
    logic [1:0]       byte_mode;
    logic [CNT_W-1:0] match_count;
    logic             match_count_valid;

    modport master (
        output start, key, last_byte, begin_gap, end_gap, mask, key_length, byte_mode,
        input  match_count, match_count_valid
    );

    modport slave (
        input  start, key, last_byte, begin_gap, end_gap, mask, key_length, byte_mode,
        output match_count, match_count_valid
    );
endinterface

// File: rtl/tsp_key_feeder.sv
// tsp_key_feeder: buffers one search pattern and streams it one byte per
// cycle to the TSP matcher, then waits for the match count.
// Optional macro TSP_KEY_FEEDER_TIMEOUT_EN adds a WAIT_RESULT watchdog.
module tsp_key_feeder #(
    parameter int unsigned MAX_KEY_LEN    = 256,
    parameter int unsigned PTR_W          = 9,
    parameter int unsigned CNT_W          = 15,
    parameter int unsigned TIMEOUT_CYCLES = 65536
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pat_clear,
    input  logic              pat_we,
    input  logic [7:0]        pat_wdata,
    input  logic [2:0]        pat_wflags,
    input  logic              go,
    input  logic [1:0]        mode_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              timeout,
    output logic              overflow,
    output logic [PTR_W-1:0]  pat_len,
    output logic [CNT_W-1:0]  result_count,
    tsp_key_feeder_if.master  key_if
);
    localparam int unsigned AW = (MAX_KEY_LEN > 1) ? $clog2(MAX_KEY_LEN) : 1;

    // Reject unusable parameter sets at elaboration
    if (MAX_KEY_LEN < 2 || MAX_KEY_LEN > 511 || PTR_W < 2 ||
        (64'(1) << PTR_W) <= 64'(MAX_KEY_LEN) || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("tsp_key_feeder: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    typedef struct packed {
        logic       mask;
        logic       end_gap;
        logic       begin_gap;
        logic [7:0] data;
    } entry_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] idx_q, idx_d;
    logic [PTR_W-1:0] run_len_q, run_len_d;
    logic [1:0]       mode_q, mode_d;
    logic [CNT_W-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             start_q, start_d;
    logic [7:0]       key_q, key_d;
    logic             last_q, last_d;
    logic             bgap_q, bgap_d;
    logic             egap_q, egap_d;
    logic             mask_q, mask_d;

    logic             wr_en_c;
    logic             div_ok_c;
    logic             len_ok_c;
    logic [PTR_W-1:0] rd_idx_c;
    entry_t           rd_entry_c;

    entry_t           mem_q [MAX_KEY_LEN];

`ifdef TSP_KEY_FEEDER_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timeout_q, timeout_d;
`endif

    // Pattern storage; contents persist across runs and resets
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_q[AW'(ptr_q)] <= entry_t'({pat_wflags, pat_wdata});
        end
    end

    // Byte fetched for the next stream cycle: index 0 at go, else idx+1
    assign rd_idx_c   = (state_q == S_IDLE) ? '0 : idx_q + PTR_W'(1);
    assign rd_entry_c = mem_q[AW'(rd_idx_c)];

    // Pattern length must be a whole number of symbols for the requested mode
    always_comb begin
        unique case (mode_in)
            2'd0:    div_ok_c = 1'b1;
            2'd1:    div_ok_c = ~ptr_q[0];
            2'd2:    div_ok_c = ((ptr_q % PTR_W'(3)) == '0);
            default: div_ok_c = (ptr_q[1:0] == 2'b00);
        endcase
        len_ok_c = (ptr_q >= PTR_W'(2)) && div_ok_c;
    end

    // Next-state, buffer write control and next values of registered outputs
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        run_len_d = run_len_q;
        mode_d    = mode_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        wr_en_c   = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        start_d   = 1'b0;
        key_d     = '0;
        last_d    = 1'b0;
        bgap_d    = 1'b0;
        egap_d    = 1'b0;
        mask_d    = 1'b0;
`ifdef TSP_KEY_FEEDER_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q;
        timeout_d = timeout_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (pat_clear) begin
                    ptr_d = '0;
                    ovf_d = 1'b0;
                end else if (pat_we) begin
                    if (ptr_q < PTR_W'(MAX_KEY_LEN)) begin
                        wr_en_c = 1'b1;
                        ptr_d   = ptr_q + PTR_W'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                if (go) begin
                    if (len_ok_c) begin
                        state_d   = S_STREAM;
                        idx_d     = '0;
                        run_len_d = ptr_q;
                        mode_d    = mode_in;
                        start_d   = 1'b1;
                        key_d     = rd_entry_c.data;
                        bgap_d    = rd_entry_c.begin_gap;
                        egap_d    = rd_entry_c.end_gap;
                        mask_d    = rd_entry_c.mask;
`ifdef TSP_KEY_FEEDER_TIMEOUT_EN
                        timeout_d = 1'b0;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_STREAM: begin
                if (idx_q == run_len_q - PTR_W'(1)) begin
                    state_d = S_WAIT;
`ifdef TSP_KEY_FEEDER_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end else begin
                    idx_d  = idx_q + PTR_W'(1);
                    key_d  = rd_entry_c.data;
                    bgap_d = rd_entry_c.begin_gap;
                    egap_d = rd_entry_c.end_gap;
                    mask_d = rd_entry_c.mask;
                    last_d = ((idx_q + PTR_W'(2)) == run_len_q);
                end
            end

            S_WAIT: begin
                if (key_if.match_count_valid) begin
                    result_d = key_if.match_count;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
`ifdef TSP_KEY_FEEDER_TIMEOUT_EN
                end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    result_d  = '0;
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
`endif
                end
            end

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            run_len_q <= '0;
            mode_q    <= '0;
            result_q  <= '0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            start_q   <= 1'b0;
            key_q     <= '0;
            last_q    <= 1'b0;
            bgap_q    <= 1'b0;
            egap_q    <= 1'b0;
            mask_q    <= 1'b0;
`ifdef TSP_KEY_FEEDER_TIMEOUT_EN
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            run_len_q <= run_len_d;
            mode_q    <= mode_d;
            result_q  <= result_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            start_q   <= start_d;
            key_q     <= key_d;
            last_q    <= last_d;
            bgap_q    <= bgap_d;
            egap_q    <= egap_d;
            mask_q    <= mask_d;
`ifdef TSP_KEY_FEEDER_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

`ifdef TSP_KEY_FEEDER_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign busy                = busy_q;
    assign done                = done_q;
    assign err                 = err_q;
    assign overflow            = ovf_q;
    assign pat_len             = ptr_q;
    assign result_count        = result_q;
    assign key_if.start        = start_q;
    assign key_if.key          = key_q;
    assign key_if.last_byte    = last_q;
    assign key_if.begin_gap    = bgap_q;
    assign key_if.end_gap      = egap_q;
    assign key_if.mask         = mask_q;
    assign key_if.key_length   = 9'(run_len_q);
    assign key_if.byte_mode    = mode_q;
endmodule

// File: tb/tb_tsp_key_feeder.sv
// Scoreboard bench for tsp_key_feeder: the driver pushes expected key beats,
// error pulses and results; a negedge monitor pops and compares them.
module tb_tsp_key_feeder;
    localparam int unsigned MAX_KEY_LEN = 256;
    localparam int unsigned PTR_W       = 9;
    localparam int unsigned CNT_W       = 15;
    localparam int unsigned TMO         = 16;

    typedef struct packed {
        logic       start;
        logic [7:0] key;
        logic       last;
        logic       bgap;
        logic       egap;
        logic       mask;
        logic [8:0] klen;
        logic [1:0] bmode;
    } beat_t;

    typedef struct packed {
        logic [CNT_W-1:0] count;
        logic             tmo;
    } res_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             pat_clear = 1'b0;
    logic             pat_we = 1'b0;
    logic [7:0]       pat_wdata = '0;
    logic [2:0]       pat_wflags = '0;
    logic             go = 1'b0;
    logic [1:0]       mode_in = '0;
    logic             busy, done, err, timeout, overflow;
    logic [PTR_W-1:0] pat_len;
    logic [CNT_W-1:0] result_count;

    tsp_key_feeder_if #(.CNT_W(CNT_W)) kif ();

    tsp_key_feeder #(
        .MAX_KEY_LEN(MAX_KEY_LEN), .PTR_W(PTR_W), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .pat_clear(pat_clear), .pat_we(pat_we),
        .pat_wdata(pat_wdata), .pat_wflags(pat_wflags), .go(go), .mode_in(mode_in),
        .busy(busy), .done(done), .err(err), .timeout(timeout), .overflow(overflow),
        .pat_len(pat_len), .result_count(result_count), .key_if(kif)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Scoreboard queues and reference model of the pattern buffer
    beat_t       exp_beats[$];
    res_t        exp_res[$];
    int          exp_err = 0;
    logic [10:0] model_buf[$];
    logic        model_ovf = 1'b0;
    logic        model_tmo = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: unexpected output, actual=%0h required=nothing", name, act);
    endtask

    // Monitor: compares every DUT output event against the scoreboard
    logic rst_seen = 1'b0;
    logic in_frame = 1'b0;
    always @(posedge clk) rst_seen <= reset;

    always @(negedge clk) begin
        beat_t act;
        beat_t e;
        res_t  r;
        act = {kif.start, kif.key, kif.last_byte, kif.begin_gap, kif.end_gap,
               kif.mask, kif.key_length, kif.byte_mode};
        if (rst_seen) begin
            exp_beats.delete();
            exp_res.delete();
            exp_err  = 0;
            in_frame = 1'b0;
            check("reset_outputs",
                  64'({busy, done, err, timeout, overflow, pat_len, result_count, act}), 64'(0));
        end else begin
            if (kif.start || in_frame) begin
                if (exp_beats.size() == 0) begin
                    unexpected("beat", 64'(act));
                end else begin
                    e = exp_beats.pop_front();
                    check("beat", 64'(act), 64'(e));
                end
                in_frame = !kif.last_byte;
            end else if (|{kif.key, kif.last_byte, kif.begin_gap, kif.end_gap, kif.mask}) begin
                unexpected("idle_strobes", 64'(act));
            end
            if (done) begin
                if (exp_res.size() == 0) begin
                    unexpected("done", 64'(result_count));
                end else begin
                    r = exp_res.pop_front();
                    check("result", 64'({result_count, timeout}), 64'(r));
                    check("busy_at_done", 64'(busy), 64'(0));
                end
            end
            if (err) begin
                if (exp_err == 0) begin
                    unexpected("err", 64'(err));
                end else begin
                    exp_err--;
                    check("busy_at_err", 64'(busy), 64'(0));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit pending();
        return (exp_beats.size() != 0) || (exp_err != 0) || (exp_res.size() != 0);
    endfunction

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (pending() && n < budget) begin
            tick();
            n++;
        end
        if (pending()) begin
            checks++;
            errors++;
            $display("FAIL %s: wait expired, actual pending beats=%0d errs=%0d results=%0d required=0",
                     name, exp_beats.size(), exp_err, exp_res.size());
            exp_beats.delete();
            exp_res.delete();
            exp_err = 0;
        end
    endtask

    task automatic write_byte(input logic [7:0] d, input logic [2:0] f);
        pat_we = 1'b1;
        pat_wdata = d;
        pat_wflags = f;
        tick();
        pat_we = 1'b0;
        if (model_buf.size() < MAX_KEY_LEN) model_buf.push_back({f, d});
        else model_ovf = 1'b1;
    endtask

    task automatic clear_buf();
        pat_clear = 1'b1;
        tick();
        pat_clear = 1'b0;
        model_buf.delete();
        model_ovf = 1'b0;
    endtask

    task automatic pulse_valid(input logic [CNT_W-1:0] cnt);
        kif.match_count_valid = 1'b1;
        kif.match_count = cnt;
        tick();
        kif.match_count_valid = 1'b0;
        kif.match_count = CNT_W'($urandom);
    endtask

    // Issue go; accepted runs are expected to stream the model buffer verbatim
    task automatic issue_go(input logic [1:0] mode, output bit ok);
        int n;
        beat_t b;
        n  = model_buf.size();
        ok = (n >= 2) && ((n % (int'(mode) + 1)) == 0);
        if (ok) begin
            for (int i = 0; i < n; i++) begin
                b.start = (i == 0);
                b.key   = model_buf[i][7:0];
                b.last  = (i == n - 1);
                b.bgap  = model_buf[i][8];
                b.egap  = model_buf[i][9];
                b.mask  = model_buf[i][10];
                b.klen  = 9'(n);
                b.bmode = mode;
                exp_beats.push_back(b);
            end
            model_tmo = 1'b0;
        end else begin
            exp_err++;
        end
        go = 1'b1;
        mode_in = mode;
        tick();
        go = 1'b0;
        mode_in = 2'($urandom);
        check(ok ? "busy_after_go" : "busy_after_reject", 64'(busy), 64'(ok));
        wait_idle("stream", n + 8);
    endtask

    task automatic run(input logic [1:0] mode, input logic [CNT_W-1:0] cnt,
                       input int delay, input bit poke, output bit ok);
        res_t r;
        issue_go(mode, ok);
        if (ok) begin
            if (poke) begin
                pat_we = 1'b1;
                pat_wdata = 8'($urandom);
                pat_clear = 1'($urandom);
                tick();
                pat_we = 1'b0;
                pat_clear = 1'b0;
            end
            repeat (delay) tick();
            r.count = cnt;
            r.tmo   = 1'b0;
            exp_res.push_back(r);
            pulse_valid(cnt);
            wait_idle("result", 8);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n;
        logic [1:0] m;
        kif.match_count_valid = 1'b0;
        kif.match_count = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // ABCD, 1-byte mode, count 7
        write_byte(8'h41, 3'b000);
        write_byte(8'h42, 3'b000);
        write_byte(8'h43, 3'b000);
        write_byte(8'h44, 3'b000);
        check("pat_len_abcd", 64'(pat_len), 64'(4));
        run(2'd0, CNT_W'(7), 2, 1'b0, ok);
        check("result_abcd", 64'(result_count), 64'(7));
        check("busy_abcd", 64'(busy), 64'(0));

        // Same pattern reissued with go alone
        run(2'd1, CNT_W'(12), 0, 1'b1, ok);

        // Three bytes in 2-byte mode and a single byte are both rejected
        clear_buf();
        for (int i = 0; i < 3; i++) write_byte(8'(8'h10 + i), 3'b000);
        run(2'd1, CNT_W'(1), 0, 1'b0, ok);
        clear_buf();
        write_byte(8'h55, 3'b000);
        run(2'd0, CNT_W'(1), 0, 1'b0, ok);

        // Fill past capacity, then clear
        clear_buf();
        for (int i = 0; i < MAX_KEY_LEN + 1; i++) write_byte(8'($urandom), 3'($urandom));
        check("pat_len_full", 64'(pat_len), 64'(model_buf.size()));
        check("overflow_set", 64'(overflow), 64'(model_ovf));
        run(2'd3, CNT_W'(16'h1234), 1, 1'b0, ok);
        clear_buf();
        check("pat_len_cleared", 64'(pat_len), 64'(0));
        check("overflow_cleared", 64'(overflow), 64'(0));

        // Per-byte flags: mask on byte 0, begin_gap on 1, end_gap on 2
        write_byte(8'hA0, 3'b100);
        write_byte(8'hA1, 3'b001);
        write_byte(8'hA2, 3'b010);
        run(2'd0, CNT_W'(3), 1, 1'b0, ok);

        // Reset on the second stream cycle aborts without done
        clear_buf();
        for (int i = 0; i < 4; i++) write_byte(8'(8'h60 + i), 3'b000);
        exp_beats.push_back({1'b1, 8'h60, 1'b0, 1'b0, 1'b0, 1'b0, 9'd4, 2'd0});
        exp_beats.push_back({1'b0, 8'h61, 1'b0, 1'b0, 1'b0, 1'b0, 9'd4, 2'd0});
        go = 1'b1;
        mode_in = 2'd0;
        tick();
        go = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_buf.delete();
        model_ovf = 1'b0;
        model_tmo = 1'b0;
        tick();
        check("busy_after_reset", 64'(busy), 64'(0));
        check("pat_len_after_reset", 64'(pat_len), 64'(0));
        pulse_valid(CNT_W'(99));
        repeat (3) tick();

`ifdef TSP_KEY_FEEDER_TIMEOUT_EN
        // Watchdog expiry, then the next accepted go clears timeout
        begin
            res_t r;
            write_byte(8'h01, 3'b000);
            write_byte(8'h02, 3'b000);
            issue_go(2'd1, ok);
            r.count = '0;
            r.tmo   = 1'b1;
            exp_res.push_back(r);
            n = 0;
            while (!done && n < TMO + 8) begin
                tick();
                n++;
            end
            check("timeout_latency", 64'(n), 64'(TMO));
            wait_idle("timeout_result", 4);
            check("timeout_sticky", 64'(timeout), 64'(1));
            run(2'd0, CNT_W'(5), 0, 1'b0, ok);
            check("timeout_cleared", 64'(timeout), 64'(0));
        end
`endif

        // Randomized patterns, modes, counts and result latencies
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 1) == 1) pulse_valid(CNT_W'($urandom));
            clear_buf();
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) write_byte(8'($urandom), 3'($urandom));
            check("pat_len_rand", 64'(pat_len), 64'(model_buf.size()));
            m = 2'($urandom_range(0, 3));
            run(m, CNT_W'($urandom), $urandom_range(0, 4), 1'($urandom), ok);
            if (ok && $urandom_range(0, 1) == 1) begin
                run(2'($urandom_range(0, 3)), CNT_W'($urandom), $urandom_range(0, 3), 1'b0, ok);
            end
            check("pat_len_persist", 64'(pat_len), 64'(model_buf.size()));
            check("result_hold", 64'(busy), 64'(0));
        end

        repeat (3) tick();
        wait_idle("final", 4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
